// File: rtl/logic_unit_seq.sv
// Serial bitwise logic unit: CHUNK bits per cycle, LSB first, NZVC flags.
// Ports: clk/reset, in_valid/in_ready + op/set_flags/in_a/in_b, out_valid/out_ready + out/flags_n_z_v_c, busy.
module logic_unit_seq #(
  parameter int SIZE  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            set_flags,
  input  logic [SIZE-1:0] in_a,
  input  logic [SIZE-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out,
  output logic [3:0]      flags_n_z_v_c,
  output logic            busy
);

  localparam int K  = SIZE / CHUNK;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_TST = 3'b111;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            sf_q, sf_d;
  logic [SIZE-1:0] res_q, res_d;
  logic            zacc_q, zacc_d;
  logic [SIZE-1:0] out_q, out_d;
  logic [3:0]      flags_q, flags_d;

  logic [CHUNK-1:0] a_s, b_s, slice;
  logic [SIZE-1:0]  res_shift;

  assign a_s = a_q[CHUNK-1:0];
  assign b_s = b_q[CHUNK-1:0];

  always_comb begin
    slice = a_s & b_s;
    unique case (op_q)
      3'b000:  slice = a_s & b_s;
      3'b001:  slice = a_s | b_s;
      3'b010:  slice = a_s ^ b_s;
      3'b011:  slice = ~(a_s | b_s);
      3'b100:  slice = ~(a_s & b_s);
      3'b101:  slice = ~(a_s ^ b_s);
      3'b110:  slice = a_s & ~b_s;
      default: slice = a_s & b_s;
    endcase
  end

  // Result fills from the top; after K shifts slice 0 sits at the LSB.
  generate
    if (K == 1) begin : g_one
      assign res_shift = slice;
    end else begin : g_multi
      assign res_shift = {slice, res_q[SIZE-1:CHUNK]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sf_d    = sf_q;
    res_d   = res_q;
    zacc_d  = zacc_q;
    out_d   = out_q;
    flags_d = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = op;
          sf_d    = set_flags;
          idx_d   = '0;
          zacc_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d    = a_q >> CHUNK;
        b_d    = b_q >> CHUNK;
        res_d  = res_shift;
        zacc_d = zacc_q | (|slice);
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = S_DONE;
          if (op_q != OP_TST) out_d = res_shift;
          if (sf_q || op_q == OP_TST)
            flags_d = {res_shift[SIZE-1], ~(zacc_q | (|slice)), 2'b00};
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sf_q    <= 1'b0;
      res_q   <= '0;
      zacc_q  <= 1'b0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sf_q    <= sf_d;
      res_q   <= res_d;
      zacc_q  <= zacc_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign out           = out_q;
  assign flags_n_z_v_c = flags_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq: K=4 instance plus a K=1 instance.
// Checks reset, ops, flags, latency, backpressure and mid-run reset.
module tb_logic_unit_seq;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, set_flags, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] in_a, in_b, out;
  logic [3:0]  flags;

  logic        in_valid2, in_ready2, set_flags2, out_valid2, out_ready2, busy2;
  logic [2:0]  op2;
  logic [31:0] in_a2, in_b2, out2;
  logic [3:0]  flags2;

  int n_checks = 0;
  int n_fail   = 0;

  logic_unit_seq #(.SIZE(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .set_flags(set_flags),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags_n_z_v_c(flags), .busy(busy)
  );

  logic_unit_seq #(.SIZE(32), .CHUNK(32)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op2), .set_flags(set_flags2),
    .in_a(in_a2), .in_b(in_b2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out(out2), .flags_n_z_v_c(flags2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request on dut and wait for out_valid; leaves it in DONE.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic sf,
                        output int lat);
    bit ir_bad;
    ir_bad    = 1'b0;
    out_ready = 1'b0;
    op        = o;
    in_a      = a;
    in_b      = b;
    set_flags = sf;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_a      = ~a;
    in_b      = ~b;
    op        = ~o;
    set_flags = ~sf;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (in_ready) ir_bad = 1'b1;
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check("in_ready_low_in_run", {31'd0, ir_bad}, 32'd0);
  endtask

  task automatic release_done;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("back_to_idle", {30'd0, in_ready, out_valid}, 32'h2);
  endtask

  initial begin
    int lat;
    bit seen;
    reset = 1'b1;
    in_valid = 0; out_ready = 0; op = 0; set_flags = 0; in_a = 0; in_b = 0;
    in_valid2 = 0; out_ready2 = 0; op2 = 0; set_flags2 = 0;
    in_a2 = 0; in_b2 = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    check("rst_out", out, 32'h0);
    check("rst_flags", {28'd0, flags}, 32'h0);
    check("rst_ctl", {29'd0, in_ready, out_valid, busy}, 32'h4);

    run_op(3'b000, 32'hF0F0_1234, 32'hFF00_FF00, 1'b1, lat);
    check("and_latency", lat, 4);
    check("and_out", out, 32'hF000_1200);
    check("and_flags", {28'd0, flags}, 32'h8);
    check("and_busy", {31'd0, busy}, 32'h1);
    release_done();

    run_op(3'b010, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, lat);
    check("xor_out", out, 32'h0);
    check("xor_flags", {28'd0, flags}, 32'h4);
    release_done();

    run_op(3'b011, 32'h0, 32'h0, 1'b0, lat);
    check("nor_out", out, 32'hFFFF_FFFF);
    check("nor_flags_hold", {28'd0, flags}, 32'h4);
    release_done();

    run_op(3'b111, 32'h8000_0000, 32'h8000_0001, 1'b0, lat);
    check("tst_out_hold", out, 32'hFFFF_FFFF);
    check("tst_flags", {28'd0, flags}, 32'h8);
    release_done();

    run_op(3'b110, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, lat);
    check("bic_out", out, 32'hFFFF_0000);
    check("bic_flags_hold", {28'd0, flags}, 32'h8);
    release_done();

    run_op(3'b001, 32'h0000_0001, 32'h0000_0002, 1'b1, lat);
    check("or_out", out, 32'h0000_0003);
    check("or_flags", {28'd0, flags}, 32'h0);
    in_valid = 1'b1;
    in_a = 32'h1234_5678;
    in_b = 32'hFFFF_FFFF;
    op = 3'b101;
    set_flags = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ctl", {29'd0, in_ready, out_valid, busy}, 32'h3);
      check("bp_out", out, 32'h0000_0003);
      check("bp_flags", {28'd0, flags}, 32'h0);
    end
    in_valid = 1'b0;
    release_done();
    check("bp_out_after", out, 32'h0000_0003);

    op = 3'b101; in_a = 32'h0; in_b = 32'h0; set_flags = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("mrst_out", out, 32'h0);
    check("mrst_flags", {28'd0, flags}, 32'h0);
    check("mrst_ctl", {29'd0, in_ready, out_valid, busy}, 32'h4);
    #2 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mrst_no_valid", {31'd0, seen}, 32'h0);
    check("mrst_out_later", out, 32'h0);

    op2 = 3'b001; in_a2 = 32'h0F0F_0000; in_b2 = 32'h0000_00F0;
    set_flags2 = 1'b1;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (out_valid2) begin
        lat = n;
        break;
      end
    end
    check("k1_latency", lat, 1);
    check("k1_out", out2, 32'h0F0F_00F0);
    check("k1_flags", {28'd0, flags2}, 32'h0);
    out_ready2 = 1'b1;
    tick();
    check("k1_idle", {30'd0, in_ready2, out_valid2}, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_seq.md
Name: logic_unit_seq

Overview:
Parametrised, multi-cycle bitwise logic unit with a selectable operation and a registered NZVC flag register. Operands are processed LSB-first in CHUNK-bit slices over SIZE/CHUNK cycles, using a valid/ready handshake on input and output. It sits in the ALU beside the arithmetic units and serves area-constrained builds that serialise wide datapaths.

Parameters:
SIZE, 32, operand/result width in bits
CHUNK, 8, bits processed per cycle; SIZE must be an integer multiple of CHUNK; K = SIZE/CHUNK

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
op  input  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 BIC (a & ~b), 111 TST (AND, flags only)
set_flags  input  1  update flag register on completion
in_a  input  SIZE  operand A
in_b  input  SIZE  operand B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out  output  SIZE  registered result
flags_n_z_v_c  output  4  registered flags {N,Z,V,C}
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, active-high, one clock domain): state=IDLE; out=0; flags_n_z_v_c=0; out_valid=0; in_ready=1; busy=0; internal counters and registers cleared. Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1, latch in_a, in_b, op and set_flags, clear the chunk index and Z accumulator, and go to RUN. With in_valid=0, stay in IDLE.
- RUN: in_ready=0. Each edge computes slice idx (bits idx*CHUNK+CHUNK-1 down to idx*CHUNK) into the working result. The Z accumulator ORs in that slice's result bits. idx increments each edge. On the edge processing idx=K-1, go to DONE.
- Entering DONE: out_valid=1.
  - out is loaded with the working result, except for TST, where out keeps its previous value.
  - Flags load only if set_flags=1 or op=TST: N = result bit SIZE-1; Z = ~(accumulated OR); V=0; C=0.
  - When flags do not load, they hold their previous value.
  - out and flags change only on this edge, and are stable at all other times.
- Latency: out_valid rises K edges after the accepting edge. K=1 (CHUNK=SIZE) is legal and gives a single RUN cycle.
- DONE: out_valid=1, in_ready=0. The unit leaves DONE only on an edge where out_ready=1, then returns to IDLE. With out_ready=0, it holds indefinitely and all outputs stay stable.
- Throughput: one operation per K+2 cycles when out_ready is held high.
- in_valid is ignored while in_ready=0, so requests are never queued.
- Operands and op changing after the accept edge have no effect.
- All op encodings are defined; there is no illegal-op case.
- busy = (state != IDLE).

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> immediately out=0, flags=0000, in_ready=1, out_valid=0, busy=0.
- AND: SIZE=32, CHUNK=8, a=0xF0F0_1234, b=0xFF00_FF00, set_flags=1 -> out=0xF000_1200, flags=1000, out_valid high exactly 4 edges after accept; in_ready low throughout.
- XOR zero then no-flag NOR:
  - XOR 0xA5A5_A5A5 ^ 0xA5A5_A5A5, set_flags=1 -> out=0, flags=0100.
  - Then NOR 0 and 0 with set_flags=0 -> out=0xFFFF_FFFF, flags stay 0100.
- TST: a=0x8000_0000, b=0x8000_0001, set_flags=0 -> out unchanged (0xFFFF_FFFF), flags=1000. BIC a=0xFFFF_FFFF, b=0x0000_FFFF -> out=0xFFFF_0000.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE and pulse in_valid -> out_valid, out and flags stay stable, and no request is accepted.
  - Raise out_ready -> IDLE on the next edge, in_ready=1.
- Reset mid-RUN and CHUNK=SIZE:
  - Assert reset after 2 RUN edges -> IDLE, out=0, no out_valid.
  - With CHUNK=32, an OR request -> out_valid 1 edge after accept.
